// File: rtl/ysyx_23060203_icache_pkg.sv
// Shared definitions for the ysyx_23060203 instruction cache: controller
// states, AXI read-channel constants and the cacheable-range predicate.
package ysyx_23060203_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP
  } icache_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32    = 3'b010;

  // Only SDRAM/flash style regions (0x3xxx_xxxx and the upper half) are
  // allocated; everything else is device space and must be read through.
  function automatic logic is_cacheable(input logic [3:0] top_nibble);
    return top_nibble[3] || (top_nibble == 4'h3);
  endfunction

endpackage

// File: rtl/ysyx_23060203_icache_array.sv
// Direct-mapped line storage: one combinational read port, one word write
// port, per-line valid set (which also records the tag) and a global clear.
module ysyx_23060203_icache_array #(
  parameter int NSETS      = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(NSETS),
  parameter int WORD_W     = $clog2(LINE_WORDS),
  parameter int TAG_W      = 32 - IDX_W - WORD_W - 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic [31:0]       rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [31:0]       wr_data_i,
  input  logic              set_valid_i,
  input  logic [TAG_W-1:0]  set_tag_i,
  input  logic              clear_all_i
);

  logic [31:0]      data_mem [NSETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [NSETS];
  logic [NSETS-1:0] valid_q;

  assign rd_data_o  = data_mem[rd_index_i][rd_word_i];
  assign rd_tag_o   = tag_mem[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

  // Data and tag writes; contents are meaningless until the valid bit is set.
  // NOTE: storage arrays get no reset -- only the valid bits need a known
  // state, and a reset on the arrays would block RAM inference.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_mem[wr_index_i][wr_word_i] <= wr_data_i;
    end
    if (set_valid_i) begin
      tag_mem[wr_index_i] <= set_tag_i;
    end
  end

  // Valid bits: global clear beats a same-cycle set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060203_icache.sv
// Blocking direct-mapped instruction cache between the IFU and an AXI read
// port. One request at a time; misses fetch a whole line with an INCR burst,
// device addresses use a single-beat read and are never allocated.
module ysyx_23060203_icache
  import ysyx_23060203_pkg::*;
#(
  parameter int NSETS      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        fencei,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam int IDX_W  = $clog2(NSETS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  icache_state_e     state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              kill_q, kill_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]  line_idx;
  logic [WORD_W-1:0] word_off;
  logic [TAG_W-1:0]  line_tag;
  logic              cacheable;
  logic [31:0]       arr_data;
  logic [TAG_W-1:0]  arr_tag;
  logic              arr_valid;
  logic              hit;
  logic              word_we;
  logic              set_valid;
  logic              beat_err;
  logic              unused_rresp_okay;

  assign line_idx  = addr_q[OFF_W +: IDX_W];
  assign word_off  = addr_q[2 +: WORD_W];
  assign line_tag  = addr_q[31 -: TAG_W];
  assign cacheable = is_cacheable(addr_q[31:28]);
  assign hit       = cacheable && arr_valid && (arr_tag == line_tag);
  assign beat_err  = err_q || rresp[1];

  // Only the SLVERR/DECERR bit matters; EXOKAY vs OKAY is irrelevant here.
  assign unused_rresp_okay = rresp[0];

  ysyx_23060203_icache_array #(
    .NSETS      (NSETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clock       (clock),
    .reset       (reset),
    .rd_index_i  (line_idx),
    .rd_word_i   (word_off),
    .rd_data_o   (arr_data),
    .rd_tag_o    (arr_tag),
    .rd_valid_o  (arr_valid),
    .wr_index_i  (line_idx),
    .wr_en_i     (word_we),
    .wr_word_i   (beat_q),
    .wr_data_i   (rdata),
    .set_valid_i (set_valid),
    .set_tag_i   (line_tag),
    .clear_all_i (fencei)
  );

  assign araddr    = cacheable ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : addr_q;
  assign arlen     = cacheable ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize    = AXI_SIZE_32;
  assign arburst   = AXI_BURST_INCR;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Controller state and response registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      kill_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      kill_q     <= kill_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    err_d      = err_q;
    drop_d     = drop_q;
    kill_d     = kill_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    word_we    = 1'b0;
    set_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = !fencei;
        if (req_valid && !fencei) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit) begin
          rsp_data_d = arr_data;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          beat_d  = '0;
          err_d   = 1'b0;
          drop_d  = 1'b0;
          kill_d  = 1'b0;
          state_d = S_MISS_AR;
        end
      end

      S_MISS_AR: begin
        arvalid = 1'b1;
        drop_d  = drop_q || flush;
        kill_d  = kill_q || fencei;
        if (arready) begin
          state_d = S_MISS_R;
        end
      end

      S_MISS_R: begin
        rready = 1'b1;
        drop_d = drop_q || flush;
        kill_d = kill_q || fencei;
        if (rvalid) begin
          word_we = cacheable;
          beat_d  = beat_q + WORD_W'(1);
          err_d   = beat_err;
          // Uncached reads are single-beat, so beat 0 is the requested word.
          if (beat_q == (cacheable ? word_off : '0)) begin
            rsp_data_d = rdata;
          end
          if (rlast) begin
            // A fence.i in this very cycle must also stop the fill.
            set_valid = cacheable && !beat_err && !kill_q && !fencei;
            rsp_err_d = beat_err;
            drop_d    = 1'b0;
            kill_d    = 1'b0;
            state_d   = (drop_q || flush) ? S_IDLE : S_RESP;
          end
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        // A redirect in the same cycle as acceptance means the word is stale.
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_icache.sv
// Self-checking bench: a randomized AXI read slave plus a line-level model
// of a 16-set, 4-word direct-mapped cache.
module tb_ysyx_23060203_icache;

  localparam int NSETS      = 16;
  localparam int LINE_BYTES = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        flush, fencei;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int checks   = 0;
  int failures = 0;

  // Slave bookkeeping and fault-injection knobs.
  int          ar_count     = 0;
  int          beat_count   = 0;
  int          ar_violation = 0;
  logic [31:0] ar_addr_last;
  logic [7:0]  ar_len_last;
  logic [2:0]  ar_size_last;
  logic [1:0]  ar_burst_last;
  int          err_beat    = -1;
  int          flush_beat  = -1;
  int          fencei_beat = -1;

  // Reference model: which line address each set currently holds.
  bit          m_valid [NSETS];
  logic [31:0] m_line  [NSETS];

  always #5 clock = ~clock;

  ysyx_23060203_icache dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .fencei    (fencei),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic bit addr_cacheable(input logic [31:0] a);
    return (a >= 32'h8000_0000) || (a >= 32'h3000_0000 && a < 32'h4000_0000);
  endfunction

  // AXI read slave with random AR and R delays.
  initial begin : axi_slave
    int          len;
    logic [31:0] base;
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && arvalid) begin
        ar_count++;
        ar_addr_last  = araddr;
        ar_len_last   = arlen;
        ar_size_last  = arsize;
        ar_burst_last = arburst;
        base = araddr;
        len  = int'(arlen);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        arready = 1'b1;
        @(posedge clock);
        #1 arready = 1'b0;
        for (int k = 0; k <= len; k++) begin
          repeat ($urandom_range(0, 1)) @(negedge clock);
          @(negedge clock);
          if (arvalid) ar_violation++;
          rvalid = 1'b1;
          rdata  = mem_word(base + 32'(4 * k));
          rresp  = (k == err_beat) ? 2'b10 : 2'b00;
          rlast  = (k == len);
          flush  = (k == flush_beat);
          fencei = (k == fencei_beat);
          for (int g = 0; g < 20 && !rready; g++) @(negedge clock);
          @(posedge clock);
          beat_count++;
          #1;
          rvalid = 1'b0;
          rlast  = 1'b0;
          rresp  = 2'b00;
          flush  = 1'b0;
          fencei = 1'b0;
        end
      end
    end
  end

  // One IFU fetch. lat counts falling edges after the request handshake
  // edge until rsp_valid is first seen; got=0 if none within max_cyc.
  task automatic fetch(input logic [31:0] a, input int max_cyc, output bit got,
                       output logic [31:0] d, output logic e, output int lat,
                       output bit stable);
    int hold;
    got = 1'b0; d = '0; e = 1'b0; lat = 0; stable = 1'b1;
    @(negedge clock);
    req_addr  = a;
    req_valid = 1'b1;
    for (int w = 0; w < 50 && !req_ready; w++) @(negedge clock);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat = c; d = rsp_data; e = rsp_err; got = 1'b1;
        hold = $urandom_range(0, 2);
        repeat (hold) begin
          @(negedge clock);
          if (!rsp_valid || rsp_data !== d || rsp_err !== e) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; fencei = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got=%b want=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got=%b want=0", rready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got=%b want=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got=%b want=0", rsp_err); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got=%b want=1", req_ready); end
  endtask

  task automatic test_cold_miss();
    bit got, st; logic [31:0] d; logic e; int lat, ar0, b0;
    ar0 = ar_count; b0 = beat_count;
    fetch(32'h3000_0008, 60, got, d, e, lat, st);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL cold_rsp: got=%b want=1", got); end
    checks++; if (ar_count - ar0 != 1) begin failures++; $display("FAIL cold_ar_count: got=%0d want=1", ar_count - ar0); end
    checks++; if (ar_addr_last !== 32'h3000_0000) begin failures++; $display("FAIL cold_araddr: got=%h want=30000000", ar_addr_last); end
    checks++; if (ar_len_last !== 8'd3) begin failures++; $display("FAIL cold_arlen: got=%0d want=3", ar_len_last); end
    checks++; if (ar_size_last !== 3'b010 || ar_burst_last !== 2'b01) begin failures++; $display("FAIL cold_size_burst: got=%b/%b want=010/01", ar_size_last, ar_burst_last); end
    checks++; if (beat_count - b0 != 4) begin failures++; $display("FAIL cold_beats: got=%0d want=4", beat_count - b0); end
    checks++; if (d !== mem_word(32'h3000_0008) || e !== 1'b0) begin failures++; $display("FAIL cold_data: got=%h/%b want=%h/0", d, e, mem_word(32'h3000_0008)); end
    checks++; if (!st) begin failures++; $display("FAIL cold_stable: got=0 want=1"); end
    ar0 = ar_count;
    fetch(32'h3000_0008, 60, got, d, e, lat, st);
    checks++; if (lat != 2 || !got) begin failures++; $display("FAIL hit_latency: got=%0d want=2", lat); end
    checks++; if (ar_count != ar0) begin failures++; $display("FAIL hit_no_ar: got=%0d want=0", ar_count - ar0); end
    checks++; if (d !== mem_word(32'h3000_0008)) begin failures++; $display("FAIL hit_data: got=%h want=%h", d, mem_word(32'h3000_0008)); end
    fetch(32'h3000_000C, 60, got, d, e, lat, st);
    checks++; if (lat != 2 || d !== mem_word(32'h3000_000C) || ar_count != ar0) begin failures++; $display("FAIL hit_same_line: lat=%0d data=%h want lat=2 data=%h", lat, d, mem_word(32'h3000_000C)); end
  endtask

  task automatic test_uncached();
    bit got, st; logic [31:0] d; logic e; int lat, ar0;
    ar0 = ar_count;
    fetch(32'h0200_0000, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 1 || ar_len_last !== 8'd0 || ar_addr_last !== 32'h0200_0000) begin failures++; $display("FAIL unc_ar: count=%0d len=%0d addr=%h want 1/0/02000000", ar_count - ar0, ar_len_last, ar_addr_last); end
    checks++; if (!got || d !== mem_word(32'h0200_0000)) begin failures++; $display("FAIL unc_data: got=%h want=%h", d, mem_word(32'h0200_0000)); end
    fetch(32'h0200_0000, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 2) begin failures++; $display("FAIL unc_repeat_ar: got=%0d want=2", ar_count - ar0); end
  endtask

  task automatic test_conflict();
    bit got, st; logic [31:0] d; logic e; int lat, ar0;
    fetch(32'h8000_0000, 60, got, d, e, lat, st);
    fetch(32'h8000_0100, 60, got, d, e, lat, st);
    ar0 = ar_count;
    fetch(32'h8000_0000, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 1 || ar_addr_last !== 32'h8000_0000) begin failures++; $display("FAIL conflict_miss: count=%0d addr=%h want 1/80000000", ar_count - ar0, ar_addr_last); end
    checks++; if (d !== mem_word(32'h8000_0000)) begin failures++; $display("FAIL conflict_data: got=%h want=%h", d, mem_word(32'h8000_0000)); end
  endtask

  task automatic test_flush_miss();
    bit got, st; logic [31:0] d; logic e; int lat, ar0, b0;
    b0 = beat_count;
    flush_beat = 1;
    fetch(32'h8000_0044, 40, got, d, e, lat, st);
    flush_beat = -1;
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL flush_no_rsp: got=%b want=0", got); end
    checks++; if (beat_count - b0 != 4) begin failures++; $display("FAIL flush_beats: got=%0d want=4", beat_count - b0); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_idle: got=%b want=1", req_ready); end
    ar0 = ar_count;
    fetch(32'h8000_0048, 60, got, d, e, lat, st);
    checks++; if (lat != 2 || ar_count != ar0 || d !== mem_word(32'h8000_0048)) begin failures++; $display("FAIL flush_refetch_hit: lat=%0d data=%h want lat=2 data=%h", lat, d, mem_word(32'h8000_0048)); end
  endtask

  task automatic test_fencei_miss();
    bit got, st; logic [31:0] d; logic e; int lat, ar0;
    fencei_beat = 2;
    fetch(32'h8000_0080, 60, got, d, e, lat, st);
    fencei_beat = -1;
    checks++; if (!got || d !== mem_word(32'h8000_0080)) begin failures++; $display("FAIL fencei_rsp: got=%b data=%h want 1/%h", got, d, mem_word(32'h8000_0080)); end
    ar0 = ar_count;
    fetch(32'h8000_0080, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 1) begin failures++; $display("FAIL fencei_kill: ar=%0d want=1", ar_count - ar0); end
    fetch(32'h8000_0044, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 2) begin failures++; $display("FAIL fencei_clear_all: ar=%0d want=2", ar_count - ar0); end
  endtask

  task automatic test_read_error();
    bit got, st; logic [31:0] d; logic e; int lat, ar0;
    err_beat = 0;
    fetch(32'h8000_0208, 60, got, d, e, lat, st);
    err_beat = -1;
    checks++; if (!got || e !== 1'b1) begin failures++; $display("FAIL err_flag: got=%b want=1", e); end
    ar0 = ar_count;
    fetch(32'h8000_0208, 60, got, d, e, lat, st);
    checks++; if (ar_count - ar0 != 1 || e !== 1'b0 || d !== mem_word(32'h8000_0208)) begin failures++; $display("FAIL err_refetch: ar=%0d err=%b data=%h want 1/0/%h", ar_count - ar0, e, d, mem_word(32'h8000_0208)); end
  endtask

  task automatic test_flush_lookup_resp();
    int ar0, seen;
    // Flush during LOOKUP of a missing line: no AR and no response.
    ar0 = ar_count; seen = 0;
    @(negedge clock); req_addr = 32'h8000_0F00; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0; flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    repeat (6) begin @(negedge clock); if (rsp_valid) seen++; end
    checks++; if (seen != 0 || ar_count != ar0) begin failures++; $display("FAIL flush_lookup: rsp=%0d ar=%0d want 0/0", seen, ar_count - ar0); end
    // Flush together with rsp_ready on a hit: back to idle, no second response.
    @(negedge clock); req_addr = 32'h8000_0208; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL resp_hit_valid: got=%b want=1", rsp_valid); end
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clock); #1 flush = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL flush_resp: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_fencei_idle();
    @(negedge clock); fencei = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fencei_req_ready: got=%b want=0", req_ready); end
    @(posedge clock); #1 fencei = 1'b0;
    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_random();
    bit got, st, exp_hit, cach; logic [31:0] d, a, line; logic e; int lat, ar0, idx;
    logic [31:0] bases [4] = '{32'h3000_0000, 32'h8000_0000, 32'h0200_0000, 32'hA000_0000};
    for (int n = 0; n < 40; n++) begin
      a    = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 127) * 4);
      cach = addr_cacheable(a);
      line = a - (a % LINE_BYTES);
      idx  = int'((a / LINE_BYTES) % NSETS);
      exp_hit = cach && m_valid[idx] && (m_line[idx] == line);
      ar0 = ar_count;
      fetch(a, 60, got, d, e, lat, st);
      checks++; if (!got || d !== mem_word(a) || e !== 1'b0 || !st) begin failures++; $display("FAIL rand_data %h: got=%h err=%b want=%h", a, d, e, mem_word(a)); end
      if (exp_hit) begin
        checks++; if (lat != 2 || ar_count != ar0) begin failures++; $display("FAIL rand_hit %h: lat=%0d ar=%0d want 2/0", a, lat, ar_count - ar0); end
      end else begin
        checks++; if (ar_count - ar0 != 1 || ar_addr_last !== (cach ? line : a) || ar_len_last !== (cach ? 8'd3 : 8'd0)) begin failures++; $display("FAIL rand_miss %h: ar=%0d addr=%h len=%0d want 1/%h/%0d", a, ar_count - ar0, ar_addr_last, ar_len_last, cach ? line : a, cach ? 3 : 0); end
        if (cach) begin m_valid[idx] = 1'b1; m_line[idx] = line; end
      end
    end
  endtask

  task automatic test_protocol();
    checks++; if (ar_violation != 0) begin failures++; $display("FAIL single_outstanding: got=%0d want=0", ar_violation); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_uncached();
    test_conflict();
    test_flush_miss();
    test_fencei_miss();
    test_read_error();
    test_flush_lookup_resp();
    test_fencei_idle();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
